// File: rtl/pio_pulse_gen.sv
// Pulse-train generator driven by a 32-bit output-PIO command word.
// Produces a burst of high/low phases and reports progress through a status word.
module pio_pulse_gen (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [31:0] cmd_word_i,
    output logic        pulse_out_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] status_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [11:0] phase_q, phase_d;
    logic [6:0]  remain_q, remain_d;
    logic [11:0] high_q, high_d;
    logic [11:0] low_q, low_d;
    logic        done_sticky_q, done_sticky_d;
    logic        abort_sticky_q, abort_sticky_d;
    logic        go_prev_q;
    logic        pulse_q, busy_q, done_q;

    logic        go;
    logic        start;
    logic [11:0] cmd_high;
    logic [11:0] cmd_low;
    logic [6:0]  cmd_count;

    assign go        = cmd_word_i[31];
    assign start     = go & ~go_prev_q;
    assign cmd_count = cmd_word_i[30:24];
    // Zero-length phases are stretched to one cycle so every phase is observable.
    assign cmd_high  = (cmd_word_i[11:0]  == 12'd0) ? 12'd1 : cmd_word_i[11:0];
    assign cmd_low   = (cmd_word_i[23:12] == 12'd0) ? 12'd1 : cmd_word_i[23:12];

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        remain_d       = remain_q;
        high_d         = high_q;
        low_d          = low_q;
        done_sticky_d  = done_sticky_q;
        abort_sticky_d = abort_sticky_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    abort_sticky_d = 1'b0;
                    if (cmd_count != 7'd0) begin
                        high_d        = cmd_high;
                        low_d         = cmd_low;
                        remain_d      = cmd_count;
                        phase_d       = cmd_high - 12'd1;
                        done_sticky_d = 1'b0;
                        state_d       = ST_HIGH;
                    end else begin
                        remain_d = 7'd0;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_HIGH: begin
                if (!go) begin
                    state_d        = ST_IDLE;
                    phase_d        = 12'd0;
                    remain_d       = 7'd0;
                    abort_sticky_d = 1'b1;
                end else if (phase_q == 12'd0) begin
                    remain_d = remain_q - 7'd1;
                    if (remain_q == 7'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        phase_d = low_q - 12'd1;
                        state_d = ST_LOW;
                    end
                end else begin
                    phase_d = phase_q - 12'd1;
                end
            end
            ST_LOW: begin
                if (!go) begin
                    state_d        = ST_IDLE;
                    phase_d        = 12'd0;
                    remain_d       = 7'd0;
                    abort_sticky_d = 1'b1;
                end else if (phase_q == 12'd0) begin
                    phase_d = high_q - 12'd1;
                    state_d = ST_HIGH;
                end else begin
                    phase_d = phase_q - 12'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_DONE) begin
            done_sticky_d = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they are true flops aligned with the state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= ST_IDLE;
            phase_q        <= 12'd0;
            remain_q       <= 7'd0;
            high_q         <= 12'd0;
            low_q          <= 12'd0;
            done_sticky_q  <= 1'b0;
            abort_sticky_q <= 1'b0;
            go_prev_q      <= 1'b0;
            pulse_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            remain_q       <= remain_d;
            high_q         <= high_d;
            low_q          <= low_d;
            done_sticky_q  <= done_sticky_d;
            abort_sticky_q <= abort_sticky_d;
            go_prev_q      <= go;
            pulse_q        <= (state_d == ST_HIGH);
            busy_q         <= (state_d == ST_HIGH) || (state_d == ST_LOW);
            done_q         <= (state_d == ST_DONE);
        end
    end

    assign pulse_out_o = pulse_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign status_o    = {17'd0, remain_q, 5'd0, abort_sticky_q, done_sticky_q, busy_q};

endmodule

// File: tb/tb_pio_pulse_gen.sv
// Self-checking bench for pio_pulse_gen: directed scenarios plus random go/field traffic.
// The reference model expands each start into a per-cycle waveform plan and replays it.
module tb_pio_pulse_gen;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] cmdWord;
    logic        pulseOut;
    logic        busy;
    logic        done;
    logic [31:0] status;

    always #5 clk = ~clk;

    pio_pulse_gen dut (
        .clk_i      (clk),
        .reset_n_i  (rstN),
        .cmd_word_i (cmdWord),
        .pulse_out_o(pulseOut),
        .busy_o     (busy),
        .done_o     (done),
        .status_o   (status)
    );

    typedef struct {
        logic       pulse;
        logic       busy;
        logic       done;
        logic [6:0] rem;
    } ExpEntry;

    ExpEntry planQ[$];
    ExpEntry cur;
    logic    doneSticky;
    logic    abortSticky;
    logic    goPrev;
    int      checkCount = 0;
    int      errorCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic ExpEntry mkEntry(input logic p, input logic b, input logic d, input int r);
        ExpEntry e;
        e.pulse = p;
        e.busy  = b;
        e.done  = d;
        e.rem   = 7'(r);
        return e;
    endfunction

    // Expand a command into the exact sequence of per-cycle outputs it should produce.
    task automatic buildPlan(input logic [31:0] cmd);
        int h = (cmd[11:0] == 12'd0) ? 1 : int'(cmd[11:0]);
        int l = (cmd[23:12] == 12'd0) ? 1 : int'(cmd[23:12]);
        int n = int'(cmd[30:24]);
        planQ.delete();
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < h; k++) planQ.push_back(mkEntry(1'b1, 1'b1, 1'b0, n - i));
            if (i < n - 1)
                for (int k = 0; k < l; k++) planQ.push_back(mkEntry(1'b0, 1'b1, 1'b0, n - i - 1));
        end
        planQ.push_back(mkEntry(1'b0, 1'b0, 1'b1, 0));
    endtask

    task automatic modelReset();
        planQ.delete();
        cur         = mkEntry(1'b0, 1'b0, 1'b0, 0);
        doneSticky  = 1'b0;
        abortSticky = 1'b0;
        goPrev      = 1'b0;
    endtask

    task automatic modelStep();
        logic go = cmdWord[31];
        if (cur.busy && !go) begin
            planQ.delete();
            cur         = mkEntry(1'b0, 1'b0, 1'b0, 0);
            abortSticky = 1'b1;
        end else if (planQ.size() > 0) begin
            cur = planQ.pop_front();
        end else if (!cur.done && go && !goPrev) begin
            abortSticky = 1'b0;
            if (cmdWord[30:24] != 7'd0) doneSticky = 1'b0;
            buildPlan(cmdWord);
            cur = planQ.pop_front();
        end else begin
            cur = mkEntry(1'b0, 1'b0, 1'b0, 0);
        end
        if (cur.done) doneSticky = 1'b1;
        goPrev = go;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".pulse"},  {31'd0, pulseOut}, {31'd0, cur.pulse});
        checkOutput({tag, ".busy"},   {31'd0, busy},     {31'd0, cur.busy});
        checkOutput({tag, ".done"},   {31'd0, done},     {31'd0, cur.done});
        checkOutput({tag, ".status"}, status,
                    {17'd0, cur.rem, 5'd0, abortSticky, doneSticky, cur.busy});
    endtask

    // Inputs change only #1 after a rising edge; outputs are sampled at the same point.
    task automatic applyStimulus(input logic [31:0] cmd, input int cycles, input string tag);
        cmdWord = cmd;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            modelStep();
            #1;
            checkAll(tag);
        end
    endtask

    task automatic doReset(input string tag);
        rstN = 1'b0;
        #1;
        modelReset();
        checkAll(tag);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    function automatic logic [31:0] mkCmd(input logic go, input int cnt, input int lo, input int hi);
        return {go, 7'(cnt), 12'(lo), 12'(hi)};
    endfunction

    initial begin
        int doneAt;
        int highCycles;
        logic [31:0] nxt;
        int r;

        cmdWord = 32'd0;
        rstN    = 1'b0;
        modelReset();
        #2;
        checkAll("reset");
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(32'd0, 3, "idle");

        // Basic three-pulse burst: done must land on the 17th edge.
        doneAt     = 0;
        highCycles = 0;
        cmdWord    = mkCmd(1'b1, 3, 5, 2);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            modelStep();
            #1;
            checkAll("burst3");
            if (pulseOut) highCycles++;
            if (done && doneAt == 0) doneAt = c;
        end
        checkOutput("burst3.doneCycle", 32'(doneAt), 32'd17);
        checkOutput("burst3.highCycles", 32'(highCycles), 32'd6);

        applyStimulus(32'd0, 2, "zeroPrep");
        applyStimulus(mkCmd(1'b1, 0, 4, 4), 4, "zeroCount");

        applyStimulus(32'd0, 2, "minPrep");
        applyStimulus(mkCmd(1'b1, 2, 0, 0), 6, "minPhase");

        applyStimulus(32'd0, 2, "abortPrep");
        applyStimulus(mkCmd(1'b1, 4, 2, 3), 7, "abortRun");
        applyStimulus(mkCmd(1'b0, 4, 2, 3), 3, "abortDrop");
        checkOutput("abort.sticky", {31'd0, status[2]}, 32'd1);
        checkOutput("abort.remaining", {25'd0, status[14:8]}, 32'd0);

        applyStimulus(mkCmd(1'b1, 3, 1, 2), 2, "fieldRun");
        applyStimulus(mkCmd(1'b1, 3, 1, 9), 20, "fieldHold");
        applyStimulus(mkCmd(1'b0, 3, 1, 9), 2, "fieldDrop");
        applyStimulus(mkCmd(1'b1, 1, 1, 9), 12, "fieldRestart");

        applyStimulus(32'd0, 2, "resetPrep");
        applyStimulus(mkCmd(1'b1, 3, 4, 2), 4, "resetRun");
        doReset("resetMid");
        applyStimulus(mkCmd(1'b1, 3, 4, 2), 20, "resetRestart");

        for (int c = 0; c < 2500; c++) begin
            nxt = cmdWord;
            r   = int'($urandom_range(0, 99));
            if (cmdWord[31]) begin
                if (r < 3) nxt[31] = 1'b0;
            end else if (r < 30) begin
                nxt[31]    = 1'b1;
                nxt[11:0]  = 12'($urandom_range(0, 3));
                nxt[23:12] = 12'($urandom_range(0, 3));
                nxt[30:24] = ($urandom_range(0, 19) == 0) ? 7'd127 : 7'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 49) == 0) nxt[23:0] = 24'($urandom_range(0, 32'h00FF_FFFF));
            if ($urandom_range(0, 299) == 0) doReset("randReset");
            applyStimulus(nxt, 1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
